// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage of the 5-stage ARM pipeline: word-addressed data memory with a
// fixed number of wait states. Freezes upstream registers while an access is
// in flight and feeds gated control plus registered load data to MEM/WB.
module mem_stage_sram_ctrl #(
    parameter int BIT_NUMBER  = 32,
    parameter int MEM_WORDS   = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic [BIT_NUMBER-1:0] alu_result_in,
    input  logic [BIT_NUMBER-1:0] st_val_in,
    input  logic [3:0]            dest_in,
    output logic                  wb_en,
    output logic                  mem_r_en,
    output logic [BIT_NUMBER-1:0] alu_result,
    output logic [BIT_NUMBER-1:0] mem_data,
    output logic [3:0]            dest,
    output logic                  freeze,
    output logic                  addr_err
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BIT_NUMBER-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [BIT_NUMBER-1:0] mem_q [MEM_WORDS];

    logic                  req;
    logic                  isLoad;
    logic                  commit;
    logic                  addrBad;
    logic                  freezeRaw;
    logic [BIT_NUMBER-1:0] offset;
    logic [AW-1:0]         wordIdx;

    // When both enables are set the access is a store, so a load needs the
    // write enable low.
    assign req     = mem_r_en_in | mem_w_en_in;
    assign isLoad  = mem_r_en_in & ~mem_w_en_in;
    assign offset  = alu_result_in - BIT_NUMBER'(BASE_ADDR);
    assign addrBad = (alu_result_in < BIT_NUMBER'(BASE_ADDR))
                   | (offset >= BIT_NUMBER'(4 * MEM_WORDS))
                   | (alu_result_in[1:0] != 2'b00);
    assign wordIdx = offset[AW+1:2];
    assign commit  = (state_q == S_WAIT) && (cnt_q == '0);

    // Next-state logic: IDLE -> WAIT (counting wait states) -> DONE -> IDLE,
    // with the load result and error flag captured on the commit edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        freezeRaw = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    freezeRaw = 1'b1;
                    state_d   = S_WAIT;
                    cnt_d     = CW'(WAIT_CYCLES - 1);
                end
            end
            S_WAIT: begin
                freezeRaw = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = S_DONE;
                    err_d   = addrBad;
                    if (isLoad) begin
                        rdata_d = addrBad ? '0 : mem_q[wordIdx];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and load-data register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Data array has no reset; a store lands only on a clean commit edge.
    always_ff @(posedge clk) begin
        if (commit && mem_w_en_in && !addrBad) begin
            mem_q[wordIdx] <= st_val_in;
        end
    end

    // Gating also forces the stall and control outputs low while reset is held.
    assign freeze     = freezeRaw & ~rst;
    assign wb_en      = wb_en_in & ~freezeRaw & ~rst;
    assign mem_r_en   = mem_r_en_in & ~freezeRaw & ~rst;
    assign addr_err   = (state_q == S_DONE) & err_q & ~rst;
    assign mem_data   = rdata_q;
    assign alu_result = alu_result_in;
    assign dest       = dest_in;

endmodule
